logic_value_monitor: RTL and testbench

- Downstream consumer of the four-state value generator stage; samples its ten output nets as one bus every clock.
- Classifies every bit as 0, 1, x or z, keeps saturating per-category tallies, and tracks bus health with a small FSM (settled vs. faulty).
- Behavioural simulation/teaching block: x/z detection relies on case equality and is not synthesizable.

---
 rtl/logic_value_pkg.sv | 25 ++
 rtl/logic_value_classify.sv | 38 +++
 rtl/logic_value_monitor.sv | 181 ++++++++++++++++++
 tb/tb_logic_value_monitor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_value_pkg.sv
// logic_value_pkg: shared definitions for the four-state bus monitor.
//   - Monitor FSM state encodings (2 bits) and the matching enum type.
//   - Category indices used to address the per-class masks, popcounts and
//     tally counters.
package logic_value_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] OBSERVE = 2'd1;
  localparam logic [1:0] SETTLED = 2'd2;
  localparam logic [1:0] FAULT   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_OBSERVE = OBSERVE,
    ST_SETTLED = SETTLED,
    ST_FAULT   = FAULT
  } state_e;

  localparam int CAT_ZERO = 0;
  localparam int CAT_ONE  = 1;
  localparam int CAT_UNK  = 2;
  localparam int CAT_IMP  = 3;
  localparam int NCAT     = 4;

endpackage

// File: rtl/logic_value_classify.sv
// logic_value_classify: combinational four-state bit classifier.
//   i_bus  : WIDTH four-state bits under observation.
//   o_mask : per category (CAT_ZERO/ONE/UNK/IMP) a WIDTH-bit mask, exactly one
//            mask bit set per bus bit.
//   o_pop  : per category the popcount of its mask (the four sum to WIDTH).
// Classification relies on case equality against x and z, so this block is
// a behavioural/teaching model and does not synthesize to real x detection.
module logic_value_classify
  import logic_value_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int PC_W  = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]                i_bus,
  output logic [NCAT-1:0][WIDTH-1:0]      o_mask,
  output logic [NCAT-1:0][PC_W-1:0]       o_pop
);

  always_comb begin
    o_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_bus[i] === 1'b0)      o_mask[CAT_ZERO][i] = 1'b1;
      else if (i_bus[i] === 1'b1) o_mask[CAT_ONE][i]  = 1'b1;
      else if (i_bus[i] === 1'bx) o_mask[CAT_UNK][i]  = 1'b1;
      else                        o_mask[CAT_IMP][i]  = 1'b1;
    end
  end

  always_comb begin
    o_pop = '0;
    for (int c = 0; c < NCAT; c++) begin
      for (int i = 0; i < WIDTH; i++) begin
        o_pop[c] = o_pop[c] + PC_W'(o_mask[c][i]);
      end
    end
  end

endmodule

// File: rtl/logic_value_monitor.sv
// logic_value_monitor: samples a four-state bus every enabled clock, tallies
// bits by class (0/1/x/z) with saturating counters and tracks bus health.
//   clk, rst       : clock (rising edge), synchronous active-high reset.
//   i_en           : sample enable; all state holds while low.
//   i_clear        : synchronous soft clear, same effect as rst.
//   i_bus          : WIDTH-bit four-state bus.
//   o_*_cnt        : CNT_W-bit saturating tallies of 0, 1, x and z bits.
//   o_state        : IDLE=0, OBSERVE=1, SETTLED=2, FAULT=3.
//   o_settled      : registered decode of SETTLED.
//   o_fault        : registered decode of FAULT.
//   o_last_known   : last clean value that reached SETTLED.
// All outputs are registered: the sample taken at edge N is visible after N.
module logic_value_monitor
  import logic_value_pkg::*;
#(
  parameter int WIDTH         = 10,
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_bus,
  output logic [CNT_W-1:0] o_zero_cnt,
  output logic [CNT_W-1:0] o_one_cnt,
  output logic [CNT_W-1:0] o_unk_cnt,
  output logic [CNT_W-1:0] o_imp_cnt,
  output logic [1:0]       o_state,
  output logic             o_settled,
  output logic             o_fault,
  output logic [WIDTH-1:0] o_last_known
);

  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam int RUN_W = 8;
  localparam logic [RUN_W-1:0] STABLE = RUN_W'(STABLE_CYCLES);

  logic [NCAT-1:0][WIDTH-1:0] mask;
  logic [NCAT-1:0][PC_W-1:0]  pop;

  logic_value_classify #(
    .WIDTH (WIDTH),
    .PC_W  (PC_W)
  ) u_classify (
    .i_bus  (i_bus),
    .o_mask (mask),
    .o_pop  (pop)
  );

  // A sample is clean when every bit is a solid 0 or 1; its value is then
  // exactly the ones-mask.
  logic             clean;
  logic [WIDTH-1:0] sample;
  assign clean  = &(mask[CAT_ZERO] | mask[CAT_ONE]);
  assign sample = mask[CAT_ONE];

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  // Run lengths only matter up to the threshold, so they stop there.
  function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] r);
    if (r >= STABLE) return STABLE;
    return r + 1'b1;
  endfunction

  logic [NCAT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  state_e                     state_q, state_d;
  logic [RUN_W-1:0]           run_q, run_d;
  logic [RUN_W-1:0]           dirty_q, dirty_d;
  logic [WIDTH-1:0]           prev_q, prev_d;
  logic [WIDTH-1:0]           last_q, last_d;
  logic                       settled_q, settled_d;
  logic                       fault_q, fault_d;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    run_d   = run_q;
    dirty_d = dirty_q;
    prev_d  = prev_q;
    last_d  = last_q;

    if (i_clear) begin
      cnt_d   = '0;
      state_d = ST_IDLE;
      run_d   = '0;
      dirty_d = '0;
      prev_d  = '0;
      last_d  = '0;
    end else if (i_en) begin
      for (int c = 0; c < NCAT; c++) begin
        cnt_d[c] = sat_add(cnt_q[c], pop[c]);
      end

      case (state_q)
        // Leaving IDLE treats the enabling sample as the first observed one.
        ST_IDLE, ST_OBSERVE: begin
          if (clean) begin
            run_d   = (sample == prev_q) ? run_inc(run_q) : RUN_W'(1);
            dirty_d = '0;
            prev_d  = sample;
            if (run_d >= STABLE) begin
              state_d = ST_SETTLED;
              last_d  = sample;
            end else begin
              state_d = ST_OBSERVE;
            end
          end else begin
            run_d   = '0;
            dirty_d = run_inc(dirty_q);
            state_d = (dirty_d >= STABLE) ? ST_FAULT : ST_OBSERVE;
          end
        end

        // Any disturbance drops back to OBSERVE with that sample already
        // counted as the first of its run.
        ST_SETTLED: begin
          if (!(clean && (sample == prev_q))) begin
            state_d = ST_OBSERVE;
            if (clean) begin
              run_d   = RUN_W'(1);
              dirty_d = '0;
              prev_d  = sample;
            end else begin
              run_d   = '0;
              dirty_d = RUN_W'(1);
            end
          end
        end

        // FAULT is sticky; only reset or clear leaves it.
        ST_FAULT: begin
        end

        default: state_d = ST_IDLE;
      endcase
    end

    settled_d = (state_d == ST_SETTLED);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      run_q     <= '0;
      dirty_q   <= '0;
      prev_q    <= '0;
      last_q    <= '0;
      settled_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      run_q     <= run_d;
      dirty_q   <= dirty_d;
      prev_q    <= prev_d;
      last_q    <= last_d;
      settled_q <= settled_d;
      fault_q   <= fault_d;
    end
  end

  assign o_zero_cnt   = cnt_q[CAT_ZERO];
  assign o_one_cnt    = cnt_q[CAT_ONE];
  assign o_unk_cnt    = cnt_q[CAT_UNK];
  assign o_imp_cnt    = cnt_q[CAT_IMP];
  assign o_state      = state_q;
  assign o_settled    = settled_q;
  assign o_fault      = fault_q;
  assign o_last_known = last_q;

endmodule

// File: tb/tb_logic_value_monitor.sv
// Self-checking bench for logic_value_monitor: a reference model predicts the
// outputs of every cycle, the prediction is queued when stimulus is driven and
// popped and compared once the DUT has registered that sample. A second
// instance with 4-bit counters exposes saturation.
module tb_logic_value_monitor;

  localparam int W = 10;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_en = 1'b0;
  logic         i_clear = 1'b0;
  logic [W-1:0] i_bus = '0;

  logic [15:0]  zc, oc, uc, ic;
  logic [1:0]   st;
  logic         settled, fault;
  logic [W-1:0] lk;

  logic [3:0]   s_zc, s_oc, s_uc, s_ic;
  logic [1:0]   s_st;
  logic         s_settled, s_fault;
  logic [W-1:0] s_lk;

  always #5 clk = ~clk;

  logic_value_monitor #(.WIDTH(W), .CNT_W(16), .STABLE_CYCLES(S)) dut (
    .clk (clk), .rst (rst), .i_en (i_en), .i_clear (i_clear), .i_bus (i_bus),
    .o_zero_cnt (zc), .o_one_cnt (oc), .o_unk_cnt (uc), .o_imp_cnt (ic),
    .o_state (st), .o_settled (settled), .o_fault (fault), .o_last_known (lk)
  );

  logic_value_monitor #(.WIDTH(W), .CNT_W(4), .STABLE_CYCLES(S)) dut_small (
    .clk (clk), .rst (rst), .i_en (i_en), .i_clear (i_clear), .i_bus (i_bus),
    .o_zero_cnt (s_zc), .o_one_cnt (s_oc), .o_unk_cnt (s_uc), .o_imp_cnt (s_ic),
    .o_state (s_st), .o_settled (s_settled), .o_fault (s_fault), .o_last_known (s_lk)
  );

  typedef struct {
    int           z, o, u, p;
    int           z4, o4, u4, p4;
    logic [1:0]   st;
    logic [W-1:0] lk;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model state
  int           m_z, m_o, m_u, m_p;
  int           m_z4, m_o4, m_u4, m_p4;
  logic [1:0]   m_st;
  int           m_run, m_dirty;
  logic [W-1:0] m_prev, m_last;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_z = 0; m_o = 0; m_u = 0; m_p = 0;
    m_z4 = 0; m_o4 = 0; m_u4 = 0; m_p4 = 0;
    m_st = 2'd0; m_run = 0; m_dirty = 0; m_prev = '0; m_last = '0;
  endtask

  task automatic model_step(input logic r, input logic c, input logic e, input logic [W-1:0] b);
    int nz, no, nu, np;
    bit is_clean;
    nz = 0; no = 0; nu = 0; np = 0;
    if (r || c) begin
      model_reset();
      return;
    end
    if (!e) return;
    for (int i = 0; i < W; i++) begin
      if (b[i] === 1'b0)      nz++;
      else if (b[i] === 1'b1) no++;
      else if (b[i] === 1'bx) nu++;
      else                    np++;
    end
    m_z = sat(m_z + nz, 65535); m_o = sat(m_o + no, 65535);
    m_u = sat(m_u + nu, 65535); m_p = sat(m_p + np, 65535);
    m_z4 = sat(m_z4 + nz, 15); m_o4 = sat(m_o4 + no, 15);
    m_u4 = sat(m_u4 + nu, 15); m_p4 = sat(m_p4 + np, 15);
    is_clean = (nu == 0) && (np == 0);
    if (m_st == 2'd0 || m_st == 2'd1) begin
      if (is_clean) begin
        m_run = (b == m_prev) ? sat(m_run + 1, S) : 1;
        m_dirty = 0;
        m_prev = b;
        if (m_run >= S) begin m_st = 2'd2; m_last = b; end
        else m_st = 2'd1;
      end else begin
        m_run = 0;
        m_dirty = sat(m_dirty + 1, S);
        m_st = (m_dirty >= S) ? 2'd3 : 2'd1;
      end
    end else if (m_st == 2'd2) begin
      if (!(is_clean && b == m_prev)) begin
        m_st = 2'd1;
        if (is_clean) begin m_run = 1; m_dirty = 0; m_prev = b; end
        else begin m_run = 0; m_dirty = 1; end
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic e, input logic [W-1:0] b);
    exp_t x;
    @(negedge clk);
    rst = r; i_clear = c; i_en = e; i_bus = b;
    model_step(r, c, e, b);
    x.z = m_z; x.o = m_o; x.u = m_u; x.p = m_p;
    x.z4 = m_z4; x.o4 = m_o4; x.u4 = m_u4; x.p4 = m_p4;
    x.st = m_st; x.lk = m_last;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check_val("zero_cnt", 32'(zc), 32'(x.z));
    check_val("one_cnt", 32'(oc), 32'(x.o));
    check_val("unk_cnt", 32'(uc), 32'(x.u));
    check_val("imp_cnt", 32'(ic), 32'(x.p));
    check_val("state", 32'(st), 32'(x.st));
    check_val("settled", 32'(settled), 32'(x.st == 2'd2));
    check_val("fault", 32'(fault), 32'(x.st == 2'd3));
    check_val("last_known", 32'(lk), 32'(x.lk));
    check_val("small_zero_cnt", 32'(s_zc), 32'(x.z4));
    check_val("small_one_cnt", 32'(s_oc), 32'(x.o4));
    check_val("small_unk_cnt", 32'(s_uc), 32'(x.u4));
    check_val("small_imp_cnt", 32'(s_ic), 32'(x.p4));
  endtask

  logic         xprobe;
  logic [W-1:0] xbus;
  logic [W-1:0] pick [4];

  initial begin
    xprobe = 1'bx;
    xbus = {1'bx, 1'b0, 1'bx, 1'bz, 1'bx, 1'b0, 1'bx, 1'bx, 1'b1, 1'b0};
    pick[0] = 10'h2A5; pick[1] = 10'h2A5; pick[2] = 10'h100; pick[3] = 10'h3FF;
    model_reset();

    // Reset state
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 10'h3FF);
    check_val("reset_state", 32'(st), 32'd0);
    check_val("reset_one_cnt", 32'(oc), 32'd0);

    // Four-state bus: first sample, then persistence into FAULT, then clear
    step(1'b0, 1'b0, 1'b1, xbus);
    if (xprobe === 1'bx) begin
      check_val("x_first_zero", 32'(zc), 32'd3);
      check_val("x_first_unk", 32'(uc), 32'd5);
      check_val("x_first_state", 32'(st), 32'd1);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, xbus);
    if (xprobe === 1'bx) begin
      check_val("x_fault_one", 32'(oc), 32'd4);
      check_val("x_fault_unk", 32'(uc), 32'd20);
      check_val("x_fault_flag", 32'(fault), 32'd1);
    end
    step(1'b0, 1'b0, 1'b1, 10'h3FF);
    step(1'b0, 1'b1, 1'b1, 10'h3FF);
    check_val("clear_state", 32'(st), 32'd0);
    check_val("clear_zero_cnt", 32'(zc), 32'd0);

    // Clean value settles on the 4th edge, a change drops to OBSERVE
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 10'h2A5);
    check_val("settle_state", 32'(st), 32'd2);
    check_val("settle_last_known", 32'(lk), 32'h2A5);
    step(1'b0, 1'b0, 1'b1, 10'h2A5);
    step(1'b0, 1'b0, 1'b1, 10'h2A4);
    check_val("change_state", 32'(st), 32'd1);
    check_val("change_last_known", 32'(lk), 32'h2A5);

    // Enable gap does not break a run
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 10'h155);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 10'h0F0);
    check_val("gap_state_hold", 32'(st), 32'd1);
    step(1'b0, 1'b0, 1'b1, 10'h155);
    check_val("gap_settled", 32'(settled), 32'd1);
    check_val("gap_one_cnt", 32'(oc), 32'd20);
    check_val("gap_zero_cnt", 32'(zc), 32'd20);

    // Saturation of the 4-bit instance
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 10'h3FF);
    step(1'b0, 1'b0, 1'b1, 10'h3FF);
    check_val("sat_small_one", 32'(s_oc), 32'd15);
    check_val("sat_big_one", 32'(oc), 32'd20);

    // rst / i_clear mid-OBSERVE with i_en high: sample not counted
    step(1'b0, 1'b0, 1'b1, 10'h0F0);
    step(1'b1, 1'b0, 1'b1, 10'h0F0);
    check_val("midrst_one_cnt", 32'(oc), 32'd0);
    step(1'b0, 1'b0, 1'b1, 10'h0F0);
    step(1'b0, 1'b0, 1'b1, 10'h0F0);
    step(1'b0, 1'b1, 1'b1, 10'h0F0);
    check_val("midclr_state", 32'(st), 32'd0);
    check_val("midclr_zero_cnt", 32'(zc), 32'd0);

    // Mixed traffic
    for (int i = 0; i < 60; i++) begin
      step(1'b0, ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
           pick[$urandom_range(0, 3)]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
